// File: rtl/shift_right_unit_pkg.sv
// Shared constants for the serial right-shift unit: default widths and FSM encoding.
package shift_right_unit_pkg;

  localparam int unsigned WIDTH_DEFAULT   = 32;
  localparam int unsigned SHAMT_W_DEFAULT = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_right_step.sv
// One-bit right shift; the vacated MSB takes the old MSB when fill_sel_i=1, else 0.
module shift_right_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             fill_sel_i,
  output logic [WIDTH-1:0] data_o
);

  logic fill_bit;

  // Select sign or zero fill and shift by one
  always_comb begin
    fill_bit = fill_sel_i & data_i[WIDTH-1];
    data_o   = {fill_bit, data_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/shift_right_unit.sv
// Serial SRL/SRA unit: accepts an operand in IDLE, shifts one bit per cycle in SHIFT,
// pulses Done for one cycle in DONE. Out is the data register itself.
module shift_right_unit
  import shift_right_unit_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEFAULT,
  parameter int unsigned SHAMT_W = SHAMT_W_DEFAULT
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic [WIDTH-1:0]   In,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic               Arith,
  output logic [WIDTH-1:0]   Out,
  output logic               Ready,
  output logic               Done
);

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               arith_q, arith_d;
  logic [WIDTH-1:0]   step_data;

  shift_right_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data_i     (data_q),
    .fill_sel_i (arith_q),
    .data_o     (step_data)
  );

  // Next-state, counter and data-register update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    arith_d = arith_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          data_d  = In;
          cnt_d   = Shamt;
          arith_d = Arith;
          state_d = (Shamt != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        data_d = step_data;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      arith_q <= arith_d;
    end
  end

  // Outputs decoded straight from registered state
  always_comb begin
    Out   = data_q;
    Ready = (state_q == ST_IDLE);
    Done  = (state_q == ST_DONE);
  end

endmodule
